ray_frame_scheduler: RTL and testbench
======================================

# ray_frame_scheduler

Frame-level controller that sequences the ray-casting datapath across all screen columns. On each frame start it issues one ray request per column, 0 to NUM_COLS-1, to the ray engine through a req/ack handshake. It waits for the engine's completion pulse, then writes the returned wall distance into the column buffer read by the renderer. It sits between the display timing logic (frame_start) and the ray engine, and replaces ad-hoc per-ray pulse generation with a single explicit FSM.

## Interface
Parameters:
- NUM_COLS, 640: columns per frame; column index range 0..NUM_COLS-1.
- DIST_W, 16: width of ray distance result.
- TIMEOUT_CYCLES, 1023: WAIT-state watchdog limit; used only when RAY_SCHED_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  single-cycle pulse from display timing (vblank start).
- ray_req  out  1  request to ray engine; held high until ray_ack.
- ray_col  out  10  column index of the current request; stable while ray_req=1.
- ray_ack  in  1  engine accepted the request this cycle.
- ray_done  in  1  single-cycle completion pulse from the engine.
- ray_dist  in  DIST_W  distance result; valid when ray_done=1.
- col_we  out  1  column buffer write strobe, one cycle per column.
- col_addr  out  10  column buffer write address.
- col_data  out  DIST_W  column buffer write data.
- fsm_state  out  2  00 IDLE, 01 ISSUE, 10 WAIT, 11 COMMIT.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  single-cycle pulse after the last column commits.
- frame_overrun  out  1  single-cycle pulse when frame_start arrives while busy.
- ray_timeout  out  1  single-cycle pulse on watchdog expiry; constant 0 when the watchdog is compiled out.

## Operation
- All outputs are registered.
- Reset values:
  - fsm_state = IDLE; column counter col = 0.
  - ray_req, col_we, frame_done, frame_overrun, ray_timeout, busy = 0.
  - ray_col, col_addr, col_data = 0.
- IDLE: on frame_start, col <= 0 and go to ISSUE.
- ISSUE: ray_req = 1 and ray_col = col.
  - On ray_ack, go to WAIT.
  - If ray_ack and ray_done arrive in the same cycle, capture ray_dist and go directly to COMMIT.
  - A ray_done without ray_ack is ignored.
- WAIT: ray_req = 0. On ray_done, latch ray_dist and go to COMMIT.
- COMMIT: col_we = 1 for exactly one cycle, with col_addr = col and col_data = the latched distance.
  - If col == NUM_COLS-1: col <= 0, pulse frame_done, go to IDLE.
  - Otherwise: col <= col+1, go to ISSUE.
- frame_start in any non-IDLE state is ignored for sequencing and pulses frame_overrun; the current frame continues uninterrupted.
- ray_done outside ISSUE and WAIT is ignored.
- Counter arithmetic is unsigned, 10 bits. col never exceeds NUM_COLS-1; wrap to 0 happens only in COMMIT of the last column.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No partial write is issued, and no frame_done pulse is generated.

## Timing
- frame_start (cycle N) -> ray_req=1, ray_col=0 at cycle N+1.
- Normal column with ack in cycle A and done in cycle D>A: col_we in cycle D+1, and next ray_req in cycle D+2.
- Minimum column period:
  - 2 cycles when ack and done coincide (ISSUE -> COMMIT).
  - 3 cycles otherwise.
- frame_done is asserted in the same cycle as the final col_we (col_addr = NUM_COLS-1). busy drops the following cycle.
- A frame_start arriving in the IDLE cycle right after frame_done is accepted.

## Configuration
- RAY_SCHED_TIMEOUT_EN defined:
  - A WAIT-state cycle counter (cleared on entry to WAIT) expires when it reaches TIMEOUT_CYCLES.
  - On expiry: latch all-ones as the distance (maximum range, rendered as far wall), pulse ray_timeout, go to COMMIT.
  - A ray_done arriving in the same cycle as expiry takes priority: its distance is used and ray_timeout stays 0.
- Not defined: no counter is built, ray_timeout is tied to 0, and WAIT lasts until ray_done indefinitely.

## Test plan
- Full frame, engine acks immediately and returns done 5 cycles later with dist = col*3:
  - 640 col_we pulses with addresses 0..639, each with data = addr*3.
  - One frame_done, coincident with addr 639.
  - fsm_state returns to 00.
- Ack and done in the same cycle for column 7, dist = 0x1234: no WAIT cycle, col_we at the next cycle with addr 7 and data 0x1234.
- frame_start pulsed while at column 100:
  - frame_overrun pulses once.
  - Sequencing continues to 639.
  - No second frame starts until the next frame_start in IDLE.
- Reset asserted during WAIT at column 300:
  - Next cycle: all outputs zero, fsm_state 00, no col_we.
  - A subsequent frame_start begins at ray_col 0.
- Spurious ray_done while in IDLE and in ISSUE before ack: no col_we, and the state is unchanged.
- With RAY_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16, engine never sends done for column 2:
  - ray_timeout pulses, and col_we writes addr 2 with data 0xFFFF.
  - Column 3 is then requested.
  - Without the macro, the bench observes WAIT held for 1000 cycles with ray_timeout 0.

Source files
------------

// File: rtl/ray_frame_scheduler.sv
// Frame-level ray scheduler: walks columns 0..NUM_COLS-1 through the ray engine and commits distances.
// Optional WAIT watchdog is built only when RAY_SCHED_TIMEOUT_EN is defined.
module ray_frame_scheduler #(
  parameter int NUM_COLS       = 640,
  parameter int DIST_W         = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              ray_req,
  output logic [9:0]        ray_col,
  input  logic              ray_ack,
  input  logic              ray_done,
  input  logic [DIST_W-1:0] ray_dist,
  output logic              col_we,
  output logic [9:0]        col_addr,
  output logic [DIST_W-1:0] col_data,
  output logic [1:0]        fsm_state,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun,
  output logic              ray_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_WAIT   = 2'b10,
    S_COMMIT = 2'b11
  } state_t;

  localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);

  state_t            state, state_n;
  logic [9:0]        col, col_n;
  logic [DIST_W-1:0] dist_n;
  logic              wd_expire;

`ifdef RAY_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expire = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) ray_timeout <= 1'b0;
    else       ray_timeout <= wd_expire && !ray_done;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
  assign ray_timeout        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    col_n   = col;
    dist_n  = col_data;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          col_n   = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ray_ack) begin
          if (ray_done) begin
            dist_n  = ray_dist;
            state_n = S_COMMIT;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A real result beats a simultaneous watchdog expiry.
        if (ray_done) begin
          dist_n  = ray_dist;
          state_n = S_COMMIT;
        end else if (wd_expire) begin
          dist_n  = '1;
          state_n = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (col == LAST_COL) begin
          col_n   = '0;
          state_n = S_IDLE;
        end else begin
          col_n   = col + 10'd1;
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      col           <= '0;
      ray_req       <= 1'b0;
      ray_col       <= '0;
      col_we        <= 1'b0;
      col_addr      <= '0;
      col_data      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_n;
      col           <= col_n;
      ray_req       <= (state_n == S_ISSUE);
      ray_col       <= col_n;
      col_we        <= (state_n == S_COMMIT);
      busy          <= (state_n != S_IDLE);
      frame_done    <= (state_n == S_COMMIT) && (col == LAST_COL);
      frame_overrun <= frame_start && (state != S_IDLE);
      if (state_n == S_COMMIT) begin
        col_addr <= col;
        col_data <= dist_n;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler: full frame, coincident ack/done, overrun, reset mid-frame, watchdog.
module tb_ray_frame_scheduler;

  localparam int NC = 640;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, frame_start, ray_ack, ray_done;
  logic [DW-1:0] ray_dist;
  logic          ray_req, col_we, busy, frame_done, frame_overrun, ray_timeout;
  logic [9:0]    ray_col, col_addr;
  logic [DW-1:0] col_data;
  logic [1:0]    fsm_state;

  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, fd_cnt = 0, ovr_cnt = 0;
  logic [25:0] exp_q[$];

  ray_frame_scheduler #(.NUM_COLS(NC), .DIST_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .ray_req(ray_req), .ray_col(ray_col), .ray_ack(ray_ack),
    .ray_done(ray_done), .ray_dist(ray_dist),
    .col_we(col_we), .col_addr(col_addr), .col_data(col_data),
    .fsm_state(fsm_state), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .ray_timeout(ray_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Column-buffer write monitor against the queue of expected writes.
  always @(negedge clk) begin
    if (frame_overrun) ovr_cnt++;
    if (frame_done) fd_cnt++;
    if (col_we) begin
      we_cnt++;
      chk("we_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("we_addr", 32'(col_addr), 32'(e[25:16]));
        chk("we_data", 32'(col_data), 32'(e[15:0]));
      end
      chk("fdone_at_we", 32'(frame_done), 32'(col_addr == 10'(NC - 1)));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("start_req", 32'(ray_req), 32'd1);
    chk("start_col", 32'(ray_col), 32'd0);
    chk("start_state", 32'(fsm_state), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_req(input int c);
    int n;
    n = 0;
    while (!ray_req && n < 20) begin tick(); n++; end
    if (!ray_req) chk("req_wait_expired", 32'(ray_req), 32'd1);
    chk("req_col", 32'(ray_col), 32'(c));
  endtask

  // Serve one column: ack now, done dly cycles later (dly=0 means same cycle as ack).
  task automatic serve(input int c, input int dly, input logic [DW-1:0] d, input bit ovr);
    wait_req(c);
    ray_ack = 1'b1;
    frame_start = ovr;
    if (dly == 0) begin
      ray_done = 1'b1; ray_dist = d;
      exp_q.push_back({10'(c), d});
    end
    tick();
    ray_ack = 1'b0; ray_done = 1'b0; frame_start = 1'b0;
    if (ovr) chk("overrun_pulse", 32'(frame_overrun), 32'd1);
    if (dly == 0) begin
      chk("coinc_state", 32'(fsm_state), 32'd3);
    end else begin
      chk("wait_req_low", 32'(ray_req), 32'd0);
      repeat (dly - 1) tick();
      ray_done = 1'b1; ray_dist = d;
      exp_q.push_back({10'(c), d});
      tick();
      ray_done = 1'b0;
      chk("commit_state", 32'(fsm_state), 32'd3);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; ray_ack = 1'b0; ray_done = 1'b0; ray_dist = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_outs", 32'({ray_req, col_we, busy, frame_done, frame_overrun, ray_timeout}), 32'd0);
    chk("rst_buses", 32'(ray_col | col_addr) | 32'(col_data), 32'd0);

    // Full frame: dist = col*3, done 5 cycles after ack; col 7 coincident; overrun at col 100.
    start_frame();
    for (int c = 0; c < NC; c++) begin
      if (c == 7) serve(c, 0, 16'h1234, 1'b0);
      else        serve(c, 5, 16'(c * 3), c == 100);
    end
    repeat (4) tick();
    chk("frame_state_idle", 32'(fsm_state), 32'd0);
    chk("frame_busy", 32'(busy), 32'd0);
    chk("frame_no_restart", 32'(ray_req), 32'd0);
    chk("frame_we_cnt", 32'(we_cnt), 32'(NC));
    chk("frame_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("frame_ovr_cnt", 32'(ovr_cnt), 32'd1);

    // Spurious done in IDLE.
    ray_done = 1'b1; ray_dist = 16'hBEEF;
    tick();
    ray_done = 1'b0;
    chk("idle_done_state", 32'(fsm_state), 32'd0);
    chk("idle_done_we", 32'(col_we), 32'd0);

    // Reset while in WAIT at column 300.
    start_frame();
    for (int c = 0; c < 300; c++) serve(c, 2, 16'(c + 16'h0100), 1'b0);
    wait_req(300);
    ray_ack = 1'b1;
    tick();
    ray_ack = 1'b0;
    tick();
    chk("pre_rst_wait", 32'(fsm_state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", 32'(fsm_state), 32'd0);
    chk("mid_rst_outs", 32'({ray_req, col_we, busy, frame_done, frame_overrun, ray_timeout}), 32'd0);
    chk("mid_rst_buses", 32'(ray_col | col_addr) | 32'(col_data), 32'd0);
    chk("mid_rst_no_fd", 32'(fd_cnt), 32'd1);
    start_frame();

    // Spurious done in ISSUE before ack.
    ray_done = 1'b1; ray_dist = 16'hDEAD;
    tick();
    ray_done = 1'b0;
    chk("issue_done_state", 32'(fsm_state), 32'd1);
    chk("issue_done_we", 32'(col_we), 32'd0);

    serve(0, 1, 16'h0011, 1'b0);
    serve(1, 3, 16'h0022, 1'b0);
    wait_req(2);
    ray_ack = 1'b1;
    tick();
    ray_ack = 1'b0;
`ifdef RAY_SCHED_TIMEOUT_EN
    begin
      int n;
      exp_q.push_back({10'd2, 16'hFFFF});
      n = 0;
      while (!ray_timeout && n < 60) begin tick(); n++; end
      chk("timeout_pulse", 32'(ray_timeout), 32'd1);
      chk("timeout_we", 32'(col_we), 32'd1);
      tick();
      chk("timeout_single", 32'(ray_timeout), 32'd0);
      wait_req(3);
    end
`else
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
        if (fsm_state != 2'b10 || ray_timeout !== 1'b0) bad++;
        tick();
      end
      chk("wait_held_1000", 32'(bad), 32'd0);
      chk("no_timeout", 32'(ray_timeout), 32'd0);
    end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("final_idle", 32'(fsm_state), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
